// File: rtl/yacht_pkg.sv
// Shared widths, category codes and scorer state encoding for the Yacht Dice evaluator.
package yacht_pkg;

    localparam int NUM_DICE = 5;
    localparam int FACE_W   = 3;
    localparam int HIST_W   = 3;
    localparam int SUM_W    = 5;
    localparam int CAT_W    = 4;

    localparam logic [CAT_W-1:0] CAT_ACES   = 4'd0;
    localparam logic [CAT_W-1:0] CAT_TWOS   = 4'd1;
    localparam logic [CAT_W-1:0] CAT_THREES = 4'd2;
    localparam logic [CAT_W-1:0] CAT_FOURS  = 4'd3;
    localparam logic [CAT_W-1:0] CAT_FIVES  = 4'd4;
    localparam logic [CAT_W-1:0] CAT_SIXES  = 4'd5;
    localparam logic [CAT_W-1:0] CAT_CHOICE = 4'd6;
    localparam logic [CAT_W-1:0] CAT_FOUR   = 4'd7;
    localparam logic [CAT_W-1:0] CAT_FULL   = 4'd8;
    localparam logic [CAT_W-1:0] CAT_SMALL  = 4'd9;
    localparam logic [CAT_W-1:0] CAT_LARGE  = 4'd10;
    localparam logic [CAT_W-1:0] CAT_YACHT  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/yacht_face_hist.sv
// Face histogram (six counters), running pip sum and illegal-face flag.
// Latency: one cycle per inc; clr has priority over inc; no backpressure.
module yacht_face_hist
    import yacht_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          inc,
    input  logic [FACE_W-1:0]             face,
    output logic [5:0][HIST_W-1:0]        hist,
    output logic [SUM_W-1:0]              sum,
    output logic                          err_acc
);

    logic face_ok;
    assign face_ok = (face != 3'd0) && (face != 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            sum     <= '0;
            err_acc <= 1'b0;
        end else if (clr) begin
            hist    <= '0;
            sum     <= '0;
            err_acc <= 1'b0;
        end else if (inc) begin
            // Faces 0 and 7 are flagged but never counted toward any bin or the sum.
            if (face_ok) begin
                hist[face - 3'd1] <= hist[face - 3'd1] + 3'd1;
                sum               <= sum + {2'b00, face};
            end else begin
                err_acc <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/yacht_score_eval.sv
// Snapshots five dice on start, scans them into a histogram and scores one category.
// Latency start->done is 7 cycles; start is ignored while busy (no queueing).
module yacht_score_eval
    import yacht_pkg::*;
#(
    parameter int SCORE_W   = 6,
    parameter int YACHT_PTS = 50,
    parameter int SS_PTS    = 15,
    parameter int LS_PTS    = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CAT_W-1:0]    category,
    input  logic [FACE_W-1:0]   dice1,
    input  logic [FACE_W-1:0]   dice2,
    input  logic [FACE_W-1:0]   dice3,
    input  logic [FACE_W-1:0]   dice4,
    input  logic [FACE_W-1:0]   dice5,
    output logic                busy,
    output logic                done,
    output logic [SCORE_W-1:0]  score,
    output logic                err
);

    state_t state, state_nxt;

    logic [2:0]                         idx;
    logic [NUM_DICE-1:0][FACE_W-1:0]    dice_q;
    logic [CAT_W-1:0]                   cat_q;
    logic                               accept;

    logic [5:0][HIST_W-1:0]             hist;
    logic [SUM_W-1:0]                   sum;
    logic                               err_acc;

    logic [5:0]                         present;
    logic                               any2, any3, any4, any5;
    logic                               small_str, large_str;
    logic [SCORE_W-1:0]                 score_calc, score_nxt;
    logic                               err_nxt;

    assign accept = (state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_SCAN;
            ST_SCAN: if (idx == 3'(NUM_DICE - 1)) state_nxt = ST_EVAL;
            ST_EVAL: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // score/err are only written in EVAL so they hold across the next scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            dice_q <= '0;
            cat_q  <= '0;
            score  <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                dice_q <= {dice5, dice4, dice3, dice2, dice1};
                cat_q  <= category;
                idx    <= '0;
            end else if (state == ST_SCAN) begin
                idx <= idx + 3'd1;
            end
            if (state == ST_EVAL) begin
                score <= score_nxt;
                err   <= err_nxt;
            end
        end
    end

    yacht_face_hist u_hist (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .inc     (state == ST_SCAN),
        .face    (dice_q[idx]),
        .hist    (hist),
        .sum     (sum),
        .err_acc (err_acc)
    );

    always_comb begin
        present = '0;
        any2    = 1'b0;
        any3    = 1'b0;
        any4    = 1'b0;
        any5    = 1'b0;
        for (int f = 0; f < 6; f++) begin
            present[f] = (hist[f] != 3'd0);
            if (hist[f] == 3'd2) any2 = 1'b1;
            if (hist[f] == 3'd3) any3 = 1'b1;
            if (hist[f] >= 3'd4) any4 = 1'b1;
            if (hist[f] == 3'd5) any5 = 1'b1;
        end
        small_str = (&present[3:0]) | (&present[4:1]) | (&present[5:2]);
        large_str = (&present[4:0]) | (&present[5:1]);
    end

    always_comb begin
        score_calc = '0;
        case (cat_q)
            CAT_ACES, CAT_TWOS, CAT_THREES, CAT_FOURS, CAT_FIVES, CAT_SIXES:
                score_calc = SCORE_W'(hist[cat_q[2:0]]) *
                             (SCORE_W'(cat_q[2:0]) + SCORE_W'(1));
            CAT_CHOICE: score_calc = SCORE_W'(sum);
            CAT_FOUR:   score_calc = any4 ? SCORE_W'(sum) : '0;
            // With five dice a 3-bin plus a 2-bin is exactly one of each; yacht never qualifies.
            CAT_FULL:   score_calc = (any3 && any2) ? SCORE_W'(sum) : '0;
            CAT_SMALL:  score_calc = small_str ? SCORE_W'(SS_PTS) : '0;
            CAT_LARGE:  score_calc = large_str ? SCORE_W'(LS_PTS) : '0;
            CAT_YACHT:  score_calc = any5 ? SCORE_W'(YACHT_PTS) : '0;
            default:    score_calc = '0;
        endcase
        err_nxt   = err_acc || (cat_q > CAT_YACHT);
        score_nxt = err_nxt ? '0 : score_calc;
    end

endmodule

// File: tb/tb_yacht_score_eval.sv
// Table vectors, randomized ops against a rule-level model, and multi-cycle corner sequences.
module tb_yacht_score_eval;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] category;
    logic [2:0] dice1, dice2, dice3, dice4, dice5;
    logic       busy, done, err;
    logic [5:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    yacht_score_eval dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .category (category),
        .dice1    (dice1),
        .dice2    (dice2),
        .dice3    (dice3),
        .dice4    (dice4),
        .dice5    (dice5),
        .busy     (busy),
        .done     (done),
        .score    (score),
        .err      (err)
    );

    typedef struct {
        logic [4:0][2:0] d;
        logic [3:0]      c;
        int              sc;
        bit              e;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e,
                                input int cat, input int sc, input bit er);
        vec_t v;
        v.d[0] = 3'(a); v.d[1] = 3'(b); v.d[2] = 3'(c); v.d[3] = 3'(d); v.d[4] = 3'(e);
        v.c = 4'(cat); v.sc = sc; v.e = er;
        return v;
    endfunction

    // Scoring rules evaluated directly from face counts.
    function automatic void model(input logic [4:0][2:0] d, input logic [3:0] c,
                                  output int sc, output bit e);
        int cnt[7];
        int sum;
        bit has2, has3, has4, has5, sm, lg;
        for (int f = 0; f < 7; f++) cnt[f] = 0;
        sum = 0;
        e = (c >= 12);
        for (int i = 0; i < 5; i++) begin
            if (d[i] == 0 || d[i] == 7) e = 1;
            else begin cnt[d[i]]++; sum += int'(d[i]); end
        end
        has2 = 0; has3 = 0; has4 = 0; has5 = 0;
        for (int f = 1; f <= 6; f++) begin
            if (cnt[f] == 2) has2 = 1;
            if (cnt[f] == 3) has3 = 1;
            if (cnt[f] >= 4) has4 = 1;
            if (cnt[f] == 5) has5 = 1;
        end
        sm = 0;
        for (int lo = 1; lo <= 3; lo++)
            if (cnt[lo] > 0 && cnt[lo+1] > 0 && cnt[lo+2] > 0 && cnt[lo+3] > 0) sm = 1;
        lg = 0;
        for (int lo = 1; lo <= 2; lo++)
            if (cnt[lo] > 0 && cnt[lo+1] > 0 && cnt[lo+2] > 0 && cnt[lo+3] > 0 && cnt[lo+4] > 0) lg = 1;
        if (c <= 5)       sc = (int'(c) + 1) * cnt[int'(c) + 1];
        else if (c == 6)  sc = sum;
        else if (c == 7)  sc = has4 ? sum : 0;
        else if (c == 8)  sc = (has3 && has2) ? sum : 0;
        else if (c == 9)  sc = sm ? 15 : 0;
        else if (c == 10) sc = lg ? 30 : 0;
        else if (c == 11) sc = has5 ? 50 : 0;
        else              sc = 0;
        if (e) sc = 0;
    endfunction

    task automatic set_dice(input logic [4:0][2:0] d);
        dice1 = d[0]; dice2 = d[1]; dice3 = d[2]; dice4 = d[3]; dice5 = d[4];
    endtask

    // One start/done transaction; dice re-rolled right after acceptance.
    task automatic do_op(input string nm, input logic [4:0][2:0] d, input logic [3:0] c,
                         input int exp_sc, input bit exp_e);
        int lat;
        int sc_got;
        bit e_got;
        lat = -1; sc_got = 0; e_got = 0;
        @(negedge clk);
        set_dice(d);
        category = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dice1 = 3'($urandom); dice2 = 3'($urandom); dice3 = 3'($urandom);
        dice4 = 3'($urandom); dice5 = 3'($urandom);
        category = 4'($urandom);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk({nm, " busy0"}, int'(busy), 1);
            if (done) begin
                lat = k; sc_got = int'(score); e_got = err;
                break;
            end
        end
        chk({nm, " latency"}, lat, 6);
        chk({nm, " score"}, sc_got, exp_sc);
        chk({nm, " err"}, int'(e_got), int'(exp_e));
        @(negedge clk);
        chk({nm, " done_pulse"}, int'(done), 0);
        chk({nm, " idle"}, int'(busy), 0);
    endtask

    initial begin
        int exp_sc;
        bit exp_e;
        int ndone, first_done;
        logic [4:0][2:0] rd;
        logic [3:0] rc;

        vecs[0]  = mk(3,3,3,5,5,  8, 19, 0);
        vecs[1]  = mk(3,3,3,5,5, 11,  0, 0);
        vecs[2]  = mk(3,3,3,5,5,  2,  9, 0);
        vecs[3]  = mk(6,6,6,6,6, 11, 50, 0);
        vecs[4]  = mk(6,6,6,6,6,  7, 30, 0);
        vecs[5]  = mk(6,6,6,6,6,  8,  0, 0);
        vecs[6]  = mk(6,6,6,6,6,  5, 30, 0);
        vecs[7]  = mk(2,3,4,5,1, 10, 30, 0);
        vecs[8]  = mk(2,3,4,5,1,  9, 15, 0);
        vecs[9]  = mk(1,3,4,5,6,  9, 15, 0);
        vecs[10] = mk(1,3,4,5,6, 10,  0, 0);
        vecs[11] = mk(4,0,4,4,4,  7,  0, 1);
        vecs[12] = mk(1,2,3,4,5, 13,  0, 1);
        vecs[13] = mk(1,2,3,4,5,  6, 15, 0);

        reset = 1'b1; start = 1'b0; category = '0;
        dice1 = '0; dice2 = '0; dice3 = '0; dice4 = '0; dice5 = '0;
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst score", int'(score), 0);
        chk("rst err", int'(err), 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            do_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].c, vecs[i].sc, vecs[i].e);

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 5; j++)
                rd[j] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 7)
                                                    : 3'($urandom_range(1, 6));
            if (i % 4 == 0) rd = {5{rd[0]}};
            rc = 4'($urandom_range(0, 15));
            model(rd, rc, exp_sc, exp_e);
            do_op($sformatf("rnd%0d", i), rd, rc, exp_sc, exp_e);
        end

        // Starts while busy are ignored and the latched dice are used.
        @(negedge clk);
        set_dice(vecs[0].d); category = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_done = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            start = (k == 1 || k == 3);
            if (k == 0) begin dice1 = 3'd6; dice2 = 3'd6; dice3 = 3'd1; end
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = k;
                    chk("ign score", int'(score), 19);
                end
            end
        end
        start = 1'b0;
        chk("ign ndone", ndone, 1);
        chk("ign lat", first_done, 6);

        // Start held high across DONE restarts once IDLE is re-entered.
        @(negedge clk);
        set_dice(vecs[3].d); category = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 6) chk("hold done1", int'(done), 1);
            if (k == 7) begin
                chk("hold idle", int'(busy), 0);
                category = 4'd5;
                dice1 = 3'd6; dice2 = 3'd6; dice3 = 3'd6; dice4 = 3'd1; dice5 = 3'd1;
            end
            if (k == 8) chk("hold restart", int'(busy), 1);
            if (k == 10) chk("hold score kept", int'(score), 50);
            if (k == 14) begin
                chk("hold done2", int'(done), 1);
                chk("hold score2", int'(score), 18);
                start = 1'b0;
            end
            if (done) ndone++;
        end
        start = 1'b0;
        chk("hold ndone", ndone, 2);

        // Reset mid-scan returns to idle immediately with no done afterwards.
        repeat (2) @(negedge clk);
        set_dice(vecs[3].d); category = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst done", int'(done), 0);
        chk("mid rst score", int'(score), 0);
        chk("mid rst err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid rst nodone", ndone, 0);
        chk("mid rst idle", int'(busy), 0);

        do_op("post rst", vecs[0].d, 4'd8, 19, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
